// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display stages: active-low segment
// decode table, blank/off patterns and the digit index map.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [5:0] ENABLE_OFF = 6'h3F;

    localparam logic [2:0] DIG_SECS   = 3'd0;
    localparam logic [2:0] DIG_TSECS  = 3'd1;
    localparam logic [2:0] DIG_MINS   = 3'd2;
    localparam logic [2:0] DIG_TMINS  = 3'd3;
    localparam logic [2:0] DIG_HOURS  = 3'd4;
    localparam logic [2:0] DIG_THOURS = 3'd5;

    // Active-low a..g in bits 6:0, dp bit (7) off; codes A..F render blank.
    localparam logic [7:0] SEG_DECODE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
    };

    function automatic logic [7:0] seg7_lookup(input logic [3:0] bcd);
        return SEG_DECODE[bcd];
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder with a segment blank
// override (dp unaffected) and a decimal-point input.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] seg_base_s;

    // Look up the digit pattern, then apply blanking and the decimal point.
    always_comb begin
        seg_base_s = seg7_lookup(bcd);
        if (blank) begin
            seg[6:0] = 7'h7F;
        end else begin
            seg[6:0] = seg_base_s[6:0];
        end
        seg[7] = ~dp;
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexes six BCD time digits onto a common-anode display with a
// per-frame shadow latch, inter-digit blanking, leading-zero blanking and
// per-digit decimal points. Outputs are active-low and registered.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DIGIT_TICKS = 12000,
    parameter int BLANK_TICKS = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] seconds,
    input  logic [3:0] t_secs,
    input  logic [3:0] minutes,
    input  logic [3:0] t_mins,
    input  logic [3:0] hours,
    input  logic [3:0] t_hours,
    input  logic       lz_blank,
    input  logic [5:0] dp_en,
    output logic [7:0] SEG,
    output logic [5:0] ENABLE,
    output logic       frame_start
);

    localparam int TW = $clog2(DIGIT_TICKS);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);

    logic [TW-1:0] tick_r;
    logic [2:0]    idx_r;
    logic [3:0]    shadow_dig_r [6];
    logic          shadow_lz_r;
    logic [5:0]    shadow_dp_r;
    logic [7:0]    seg_r;
    logic [5:0]    enable_r;
    logic          frame_start_r;

    logic          capture_s;
    logic          in_blank_s;
    logic [3:0]    live_dig_s [6];
    logic [3:0]    sel_dig_s [6];
    logic [3:0]    cur_dig_s;
    logic          cur_lz_s;
    logic [5:0]    cur_dp_s;
    logic          dp_sel_s;
    logic          lz_hit_s;
    logic [7:0]    dec_seg_s;

    assign capture_s = (tick_r == '0) && (idx_r == DIG_SECS);

    if (BLANK_TICKS == 0) begin : g_no_blank
        assign in_blank_s = 1'b0;
    end else begin : g_blank
        localparam logic [TW-1:0] BLANK_LIMIT = TW'(BLANK_TICKS);
        assign in_blank_s = (tick_r < BLANK_LIMIT);
    end

    // Gather the live inputs and pick live (capture cycle) or shadow values.
    always_comb begin
        live_dig_s[DIG_SECS]   = seconds;
        live_dig_s[DIG_TSECS]  = t_secs;
        live_dig_s[DIG_MINS]   = minutes;
        live_dig_s[DIG_TMINS]  = t_mins;
        live_dig_s[DIG_HOURS]  = hours;
        live_dig_s[DIG_THOURS] = t_hours;
        for (int i = 0; i < 6; i++) begin
            sel_dig_s[i] = capture_s ? live_dig_s[i] : shadow_dig_r[i];
        end
        if (capture_s) begin
            cur_lz_s = lz_blank;
            cur_dp_s = dp_en;
        end else begin
            cur_lz_s = shadow_lz_r;
            cur_dp_s = shadow_dp_r;
        end
    end

    // Select the digit value and decimal point for the slot being scanned.
    always_comb begin
        case (idx_r)
            3'd0:    begin cur_dig_s = sel_dig_s[0]; dp_sel_s = cur_dp_s[0]; end
            3'd1:    begin cur_dig_s = sel_dig_s[1]; dp_sel_s = cur_dp_s[1]; end
            3'd2:    begin cur_dig_s = sel_dig_s[2]; dp_sel_s = cur_dp_s[2]; end
            3'd3:    begin cur_dig_s = sel_dig_s[3]; dp_sel_s = cur_dp_s[3]; end
            3'd4:    begin cur_dig_s = sel_dig_s[4]; dp_sel_s = cur_dp_s[4]; end
            3'd5:    begin cur_dig_s = sel_dig_s[5]; dp_sel_s = cur_dp_s[5]; end
            default: begin cur_dig_s = 4'd0;         dp_sel_s = 1'b0;        end
        endcase
        lz_hit_s = (idx_r == DIG_THOURS) && cur_lz_s && (cur_dig_s == 4'd0);
    end

    bcd_to_seg7 u_dec (
        .bcd   (cur_dig_s),
        .blank (lz_hit_s),
        .dp    (dp_sel_s),
        .seg   (dec_seg_s)
    );

    // Free-running slot tick and digit index counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r <= '0;
            idx_r  <= 3'd0;
        end else if (tick_r == TICK_LAST) begin
            tick_r <= '0;
            if (idx_r == DIG_THOURS) begin
                idx_r <= 3'd0;
            end else begin
                idx_r <= idx_r + 3'd1;
            end
        end else begin
            tick_r <= tick_r + 1'b1;
        end
    end

    // Shadow latch: take a consistent snapshot of all inputs once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                shadow_dig_r[i] <= 4'd0;
            end
            shadow_lz_r <= 1'b0;
            shadow_dp_r <= 6'd0;
        end else if (capture_s) begin
            for (int i = 0; i < 6; i++) begin
                shadow_dig_r[i] <= live_dig_s[i];
            end
            shadow_lz_r <= lz_blank;
            shadow_dp_r <= dp_en;
        end else begin
            for (int i = 0; i < 6; i++) begin
                shadow_dig_r[i] <= shadow_dig_r[i];
            end
            shadow_lz_r <= shadow_lz_r;
            shadow_dp_r <= shadow_dp_r;
        end
    end

    // Output registers: blank phase turns everything off, ON phase drives one digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r         <= SEG_BLANK;
            enable_r      <= ENABLE_OFF;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= capture_s;
            if (in_blank_s) begin
                seg_r    <= SEG_BLANK;
                enable_r <= ENABLE_OFF;
            end else begin
                seg_r    <= dec_seg_s;
                enable_r <= ~(6'b000001 << idx_r);
            end
        end
    end

    assign SEG         = seg_r;
    assign ENABLE      = enable_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with DIGIT_TICKS=4, BLANK_TICKS=1.
module tb_seg7_scan_mux;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] seconds, t_secs, minutes, t_mins, hours, t_hours;
    logic       lz_blank;
    logic [5:0] dp_en;
    logic [7:0] SEG;
    logic [5:0] ENABLE;
    logic       frame_start;

    int         n_cmp = 0;
    int         n_mis = 0;
    int         frame = 0;
    logic [7:0] exp_seg [6];
    logic [7:0] en_tab  [6];

    seg7_scan_mux #(.DIGIT_TICKS(4), .BLANK_TICKS(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .seconds     (seconds),
        .t_secs      (t_secs),
        .minutes     (minutes),
        .t_mins      (t_mins),
        .hours       (hours),
        .t_hours     (t_hours),
        .lz_blank    (lz_blank),
        .dp_en       (dp_en),
        .SEG         (SEG),
        .ENABLE      (ENABLE),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_exp(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] e5);
        exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2;
        exp_seg[3] = e3; exp_seg[4] = e4; exp_seg[5] = e5;
    endtask

    // One slot: a blank cycle then three ON cycles.
    task automatic check_slot(input int k);
        step();
        check($sformatf("f%0d_s%0d_blank_en", frame, k), {2'b00, ENABLE}, 8'h3F);
        check($sformatf("f%0d_s%0d_blank_seg", frame, k), SEG, 8'hFF);
        check($sformatf("f%0d_s%0d_fs", frame, k), {7'd0, frame_start}, (k == 0) ? 8'd1 : 8'd0);
        for (int t = 1; t < 4; t++) begin
            step();
            check($sformatf("f%0d_s%0d_t%0d_en", frame, k, t), {2'b00, ENABLE}, en_tab[k]);
            check($sformatf("f%0d_s%0d_t%0d_seg", frame, k, t), SEG, exp_seg[k]);
            check($sformatf("f%0d_s%0d_t%0d_fs", frame, k, t), {7'd0, frame_start}, 8'd0);
        end
    endtask

    task automatic run_slots(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            check_slot(k);
        end
    endtask

    initial begin
        en_tab[0] = 8'h3E; en_tab[1] = 8'h3D; en_tab[2] = 8'h3B;
        en_tab[3] = 8'h37; en_tab[4] = 8'h2F; en_tab[5] = 8'h1F;

        // Reset held three cycles with nonzero digits.
        rst = 1'b1;
        seconds = 4'd8; t_secs = 4'd8; minutes = 4'd8; t_mins = 4'd8; hours = 4'd8; t_hours = 4'd8;
        lz_blank = 1'b1; dp_en = 6'h3F;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_seg", SEG, 8'hFF);
            check("rst_en", {2'b00, ENABLE}, 8'h3F);
            check("rst_fs", {7'd0, frame_start}, 8'd0);
        end

        // F1: scan order.
        rst = 1'b0;
        seconds = 4'd1; t_secs = 4'd2; minutes = 4'd3; t_mins = 4'd4; hours = 4'd5; t_hours = 4'd0;
        lz_blank = 1'b0; dp_en = 6'h00;
        frame = 1;
        set_exp(8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'hC0);
        run_slots(0, 5);

        // F2: minutes changes while digit 4 is scanned; no effect this frame.
        frame = 2;
        run_slots(0, 3);
        minutes = 4'd7;
        run_slots(4, 5);

        // F3: new minutes visible; hours changes after slot 1 stays hidden.
        frame = 3;
        set_exp(8'hF9, 8'hA4, 8'hF8, 8'h99, 8'h92, 8'hC0);
        run_slots(0, 1);
        hours = 4'd6;
        run_slots(2, 5);

        // F4: leading-zero blanking of t_hours=0.
        frame = 4;
        lz_blank = 1'b1;
        set_exp(8'hF9, 8'hA4, 8'hF8, 8'h99, 8'h82, 8'hFF);
        run_slots(0, 5);

        // F5: t_hours=1 is not blanked.
        frame = 5;
        t_hours = 4'd1;
        set_exp(8'hF9, 8'hA4, 8'hF8, 8'h99, 8'h82, 8'hF9);
        run_slots(0, 5);

        // F6: invalid BCD renders blank.
        frame = 6;
        minutes = 4'hA;
        set_exp(8'hF9, 8'hA4, 8'hFF, 8'h99, 8'h82, 8'hF9);
        run_slots(0, 5);

        // F7: decimal point on digit 2 only.
        frame = 7;
        minutes = 4'd5; dp_en = 6'b000100;
        set_exp(8'hF9, 8'hA4, 8'h12, 8'h99, 8'h82, 8'hF9);
        run_slots(0, 5);

        // F8: dp honoured on a blank code and on a leading-zero-blanked digit.
        frame = 8;
        minutes = 4'hA; dp_en = 6'b100100; t_hours = 4'd0;
        set_exp(8'hF9, 8'hA4, 8'h7F, 8'h99, 8'h82, 8'h7F);
        run_slots(0, 5);

        // F9: reset asserted for one cycle while digit 3 is due.
        frame = 9;
        minutes = 4'd3; dp_en = 6'h00; lz_blank = 1'b0;
        set_exp(8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h82, 8'hC0);
        run_slots(0, 2);
        rst = 1'b1;
        seconds = 4'd9;
        step();
        check("midrst_en", {2'b00, ENABLE}, 8'h3F);
        check("midrst_seg", SEG, 8'hFF);
        check("midrst_fs", {7'd0, frame_start}, 8'd0);
        rst = 1'b0;

        // F10: restart at digit 0 with a fresh capture, then the next frame start.
        frame = 10;
        set_exp(8'h90, 8'hA4, 8'hB0, 8'h99, 8'h82, 8'hC0);
        run_slots(0, 5);
        frame = 11;
        check_slot(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Downstream display stage of the time-of-day clock: consumes the six BCD digits (seconds, t_secs, minutes, t_mins, hours, t_hours) and time-multiplexes them onto the 6-digit common-anode 7-segment display.
- Board outputs SEG and ENABLE are both active-low.
- Adds:
  - a per-frame shadow latch so a digit never tears mid-frame;
  - an inter-digit blanking gap against ghosting;
  - optional leading-zero blanking;
  - per-digit decimal points.

Parameters:
- DIGIT_TICKS, 12000, clk cycles per digit slot (1 ms at 12 MHz); legal range >= 2.
- BLANK_TICKS, 600, cycles at the start of each slot with all digits off; legal range 0 .. DIGIT_TICKS-1.

Ports:
- clk  in  1  system clock (12 MHz)
- rst  in  1  synchronous, active-high reset
- seconds  in  4  BCD units of seconds, digit 0
- t_secs  in  4  BCD tens of seconds, digit 1
- minutes  in  4  BCD units of minutes, digit 2
- t_mins  in  4  BCD tens of minutes, digit 3
- hours  in  4  BCD units of hours, digit 4
- t_hours  in  4  BCD tens of hours, digit 5
- lz_blank  in  1  1 = blank digit 5 when it is 0
- dp_en  in  6  dp_en[i]=1 lights the decimal point of digit i
- SEG  out  8  active-low segments: SEG[0]=a .. SEG[6]=g, SEG[7]=dp
- ENABLE  out  6  active-low digit enables: ENABLE[i] selects digit i
- frame_start  out  1  one-cycle pulse, high on the cycle the first slot of a new frame begins

Behaviour:
- Single clock domain. Reset is synchronous and active-high: one clk edge with rst=1 resets all state, and rst overrides all other activity.
- Reset values:
  - tick=0, idx=0;
  - shadow digits=0, shadow lz/dp=0;
  - SEG=8'hFF, ENABLE=6'h3F, frame_start=0.
- Internal counters:
  - tick counts 0..DIGIT_TICKS-1, then wraps to 0;
  - idx counts 0..5 and increments when tick wraps; idx wraps 5->0.
- Shadow capture: on every edge where tick==0 and idx==0 (rst low), latch all six digit inputs, lz_blank and dp_en. Display content changes only at frame boundaries.
- The first edge after rst deasserts performs a capture.
- All outputs are registered. The outputs after edge n reflect the tick/idx values present before edge n, so output latency is one cycle.
- Slot phases:
  - tick < BLANK_TICKS: ENABLE=6'h3F, SEG=8'hFF (BLANK phase).
  - otherwise (ON phase): ENABLE = ~(6'b1 << idx); SEG = decode(shadow digit idx), with SEG[7] = ~shadow_dp[idx].
- The capture cycle shows the newly captured values (decode is taken from the value being latched, i.e. bypassed).
- Decode table, dp bit off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
  - 4'hA..4'hF = FF (blank; dp still honoured)
- Leading zero: when idx==5, shadow lz_blank=1 and shadow t_hours==0, segments a..g are off (SEG[6:0]=7'h7F). ENABLE still asserts and dp is still honoured.
- frame_start is a registered pulse: high exactly for the output cycle showing idx 0, tick 0.
- Frame period = 6*DIGIT_TICKS cycles. No gaps or stalls; the counters free-run.
- BLANK_TICKS=0: no blank phase, and ENABLE is never all-off between slots.
- Reset mid-frame: the next output cycle is off (SEG=FF, ENABLE=3F). Scanning restarts at digit 0 with a fresh capture.
- Input changes within a frame have no visible effect until the next capture.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry active-low decode constants and SEG_BLANK=8'hFF;
  - ENABLE_OFF=6'h3F;
  - digit index constants DIG_SECS=0 .. DIG_THOURS=5.
- One natural sub-module: bcd_to_seg7 (combinational, 4-bit BCD + blank + dp -> 8-bit active-low SEG). Reusable by other display stages.
- Scan counters, shadow registers and output registers stay in seg7_scan_mux.

Test Plan:
All scenarios use DIGIT_TICKS=4, BLANK_TICKS=1.
1. Reset: hold rst=1 for 3 cycles with nonzero digits -> SEG=FF, ENABLE=3F, frame_start=0 throughout; after release, frame_start pulses every 24 cycles.
2. Scan order: digits 1,2,3,4,5,0 (seconds..t_hours), lz_blank=0, dp_en=0 -> each slot shows 1 cycle ENABLE=3F/SEG=FF, then 3 cycles of ENABLE=3E,3D,3B,37,2F,1F with SEG=F9,A4,B0,99,92,C0 respectively.
3. Anti-tear: change minutes 3->7 while idx=4 -> digit 2 keeps B0 for the rest of the frame; shows F8 from the next frame.
4. Leading zero: lz_blank=1, t_hours=0 -> digit 5 ON cycles SEG=FF with ENABLE=1F; then t_hours=1 -> F9 next frame.
5. Invalid BCD and dp: minutes=4'hA -> digit 2 SEG=FF; minutes=5 with dp_en=6'b000100 -> digit 2 SEG=12, other digits with SEG[7]=1.
6. Mid-frame reset: assert rst for 1 cycle while idx=3 -> following output cycle ENABLE=3F/SEG=FF, then the digit 0 slot begins immediately with frame_start=1.
